// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 Avalon responder: FSM encodings, controller
// command codes, the power-up initialisation ROM and the long-wait decode.
package lcd_pkg;

    localparam logic [1:0] ST_PWR_WAIT  = 2'd0;
    localparam logic [1:0] ST_INIT_NEXT = 2'd1;
    localparam logic [1:0] ST_IDLE      = 2'd2;
    localparam logic [1:0] ST_CYCLE     = 2'd3;

    localparam logic [2:0] BC_PWR       = 3'd0;
    localparam logic [2:0] BC_IDLE      = 3'd1;
    localparam logic [2:0] BC_SETUP     = 3'd2;
    localparam logic [2:0] BC_EN_HIGH   = 3'd3;
    localparam logic [2:0] BC_HOLD      = 3'd4;
    localparam logic [2:0] BC_EXEC_WAIT = 3'd5;

    localparam logic [7:0] CLEAR           = 8'h01;
    localparam logic [7:0] HOME            = 8'h02;
    localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] DISP_ON         = 8'h0C;
    localparam logic [7:0] ENTRY_INC       = 8'h06;

    localparam int unsigned INIT_LEN   = 6;
    localparam logic [2:0]  INIT_LEN_C = 3'd6;
    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        ENTRY_INC, CLEAR, DISP_ON, FUNC_8BIT_2LINE, FUNC_8BIT_2LINE, FUNC_8BIT_2LINE
    };

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == CLEAR) || (data == HOME) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_avalon_responder_if.sv
// Avalon-MM register-slave bus between an initiator and the LCD responder.
interface lcd_avalon_responder_if;
    logic       address;
    logic       chipselect;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, waitrequest
    );

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, waitrequest
    );
endinterface

// File: rtl/lcd_bus_cycle.sv
// One timed HD44780 transfer (setup, EN pulse, hold, execution wait); also
// times the power-up delay so a single down-counter serves every interval.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned EN_CYC    = 25,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned WAIT_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 82000,
    parameter int unsigned PWRUP_CYC = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    input  logic       long_wait_i,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o,
    output logic       done_o
);
    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LD    = 20'(EN_CYC - 1);
    localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
    localparam logic [19:0] WAIT_LD  = 20'(WAIT_CYC - 1);
    localparam logic [19:0] CLEAR_LD = 20'(CLEAR_CYC - 1);
    localparam logic [19:0] PWRUP_LD = 20'(PWRUP_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        long_q, long_d;
    logic        en_q, en_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        cnt_zero_s;

    assign cnt_zero_s = (cnt_q == 20'd0);
    assign done_o     = cnt_zero_s && ((state_q == BC_PWR) || (state_q == BC_EXEC_WAIT));
    assign lcd_en_o   = en_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

    // Phase sequencing and counter reload for each timed interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            BC_PWR: begin
                if (cnt_zero_s) state_d = BC_IDLE;
                else            cnt_d   = cnt_q - 20'd1;
            end
            BC_IDLE: begin
                if (start_i) begin
                    rs_d    = rs_i;
                    data_d  = data_i;
                    long_d  = long_wait_i;
                    cnt_d   = SETUP_LD;
                    state_d = BC_SETUP;
                end else begin
                    state_d = BC_IDLE;
                end
            end
            BC_SETUP: begin
                if (cnt_zero_s) begin
                    en_d    = 1'b1;
                    cnt_d   = EN_LD;
                    state_d = BC_EN_HIGH;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            BC_EN_HIGH: begin
                if (cnt_zero_s) begin
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = BC_HOLD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            BC_HOLD: begin
                if (cnt_zero_s) begin
                    cnt_d   = long_q ? CLEAR_LD : WAIT_LD;
                    state_d = BC_EXEC_WAIT;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            BC_EXEC_WAIT: begin
                if (cnt_zero_s) state_d = BC_IDLE;
                else            cnt_d   = cnt_q - 20'd1;
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = 20'd0;
                state_d = BC_IDLE;
            end
        endcase
    end

    // State, counter and LCD pin registers; reset drops EN asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BC_PWR;
            cnt_q   <= PWRUP_LD;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/lcd_avalon_responder.sv
// Avalon-MM responder for an HD44780 character LCD: power-up init sequencing,
// command/data register writes and a busy status register.
module lcd_avalon_responder
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned EN_CYC    = 25,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned WAIT_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 82000,
    parameter int unsigned PWRUP_CYC = 750000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    lcd_avalon_responder_if.slave        avs,
    inout  wire  [7:0]                   LCD_DATA,
    output logic                         LCD_EN,
    output logic                         LCD_RS,
    output logic                         LCD_RW,
    output logic                         LCD_ON,
    output logic                         LCD_BLON
);
    logic [1:0] state_q, state_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic       start_q, start_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       busy_s, accept_s, bc_done_s, long_wait_s;
    logic [7:0] lcd_data_s;
    logic       read_unused_s;

    // Reads are side-effect free, so the strobe itself carries no information.
    assign read_unused_s   = avs.read;
    assign busy_s          = (state_q != ST_IDLE);
    assign accept_s        = (state_q == ST_IDLE) && avs.chipselect && avs.write;
    assign avs.waitrequest = avs.chipselect && avs.write && busy_s;
    assign avs.readdata    = {busy_s, 7'b0000000};
    assign long_wait_s     = is_long_wait(rs_q, data_q);
    assign LCD_DATA        = lcd_data_s;
    assign LCD_RW          = 1'b0;
    assign LCD_ON          = 1'b1;
    assign LCD_BLON        = 1'b1;

    // Sequencer: power-up wait, init ROM walk, then host-driven transfers.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        start_d    = 1'b0;
        rs_d       = rs_q;
        data_d     = data_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (bc_done_s) state_d = ST_INIT_NEXT;
                else           state_d = ST_PWR_WAIT;
            end
            ST_INIT_NEXT: begin
                rs_d       = 1'b0;
                data_d     = INIT_ROM[init_idx_q];
                init_idx_d = init_idx_q + 3'd1;
                start_d    = 1'b1;
                state_d    = ST_CYCLE;
            end
            ST_IDLE: begin
                if (accept_s) begin
                    rs_d    = avs.address;
                    data_d  = avs.writedata;
                    start_d = 1'b1;
                    state_d = ST_CYCLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CYCLE: begin
                if (bc_done_s) begin
                    if (init_idx_q != INIT_LEN_C) state_d = ST_INIT_NEXT;
                    else                          state_d = ST_IDLE;
                end else begin
                    state_d = ST_CYCLE;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_PWR_WAIT;
            init_idx_q <= 3'd0;
            start_q    <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            start_q    <= start_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
        end
    end

    lcd_bus_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .WAIT_CYC  (WAIT_CYC),
        .CLEAR_CYC (CLEAR_CYC),
        .PWRUP_CYC (PWRUP_CYC)
    ) u_bus_cycle (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_q),
        .rs_i        (rs_q),
        .data_i      (data_q),
        .long_wait_i (long_wait_s),
        .lcd_en_o    (LCD_EN),
        .lcd_rs_o    (LCD_RS),
        .lcd_data_o  (lcd_data_s),
        .done_o      (bc_done_s)
    );
endmodule

// File: tb/tb_lcd_avalon_responder.sv
// Directed bench for lcd_avalon_responder with short timing parameters.
module tb_lcd_avalon_responder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    wire  [7:0] lcd_data;
    logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
    int         nvec = 0;
    int         nerr = 0;
    int         npulse_all = 0;
    int         npulse_41 = 0;
    logic       en_prev = 1'b0;
    logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_avalon_responder_if avs ();

    lcd_avalon_responder #(
        .SETUP_CYC (2), .EN_CYC (5), .HOLD_CYC (2),
        .WAIT_CYC (10), .CLEAR_CYC (40), .PWRUP_CYC (20)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (avs.slave),
        .LCD_DATA (lcd_data),
        .LCD_EN   (lcd_en),
        .LCD_RS   (lcd_rs),
        .LCD_RW   (lcd_rw),
        .LCD_ON   (lcd_on),
        .LCD_BLON (lcd_blon)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle while counting EN rising edges and those carrying 0x41.
    task automatic tick_mon;
        tick();
        if (lcd_en && !en_prev) begin
            npulse_all++;
            if (lcd_data == 8'h41) npulse_41++;
        end
        en_prev = lcd_en;
    endtask

    task automatic bus_idle;
        avs.chipselect = 1'b0;
        avs.read       = 1'b0;
        avs.write      = 1'b0;
        avs.address    = 1'b0;
        avs.writedata  = 8'h00;
    endtask

    task automatic wait_pulse(input logic [7:0] exp_data);
        bit found = 1'b0;
        int w = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (lcd_en) found = 1'b1;
            else        tick();
        end
        chk1("init_en_seen", found, 1'b1);
        chk1("init_rs", lcd_rs, 1'b0);
        chk8("init_data", lcd_data, exp_data);
        chk8("init_busy", avs.readdata, 8'h80);
        for (int i = 0; i < 50 && lcd_en; i++) begin
            w++;
            tick();
        end
        chk8("init_en_width", w[7:0], 8'd5);
    endtask

    // Call at posedge+1 right after reset_n has been raised.
    task automatic init_seq;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk8("pwr_readdata", avs.readdata, 8'h80);
            chk1("pwr_en", lcd_en, 1'b0);
        end
        for (int k = 0; k < 6; k++) wait_pulse(rom[k]);
        repeat (11) tick();
        chk8("init_last_busy", avs.readdata, 8'h80);
        tick();
        chk8("init_done_idle", avs.readdata, 8'h00);
    endtask

    task automatic write_check(input logic a, input logic [7:0] d, input int fall);
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = a;
        avs.writedata  = d;
        #1;
        chk1("wr_accept_wait", avs.waitrequest, 1'b0);
        chk8("wr_pre_idle", avs.readdata, 8'h00);
        tick();
        bus_idle();
        for (int c = 1; c <= fall + 2; c++) begin
            tick();
            chk1("wr_en", lcd_en, (c >= 3 && c <= 7));
            chk8("wr_busy", avs.readdata, (c < fall) ? 8'h80 : 8'h00);
            if (c == 1) begin
                chk1("wr_rs_c1", lcd_rs, a);
                chk8("wr_data_c1", lcd_data, d);
            end
        end
        chk1("wr_rs_hold", lcd_rs, a);
        chk8("wr_data_hold", lcd_data, d);
    endtask

    initial begin
        int waits;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_en", lcd_en, 1'b0);
        chk1("rst_rs", lcd_rs, 1'b0);
        chk1("rst_rw", lcd_rw, 1'b0);
        chk8("rst_data", lcd_data, 8'h00);
        chk1("rst_on", lcd_on, 1'b1);
        chk1("rst_blon", lcd_blon, 1'b1);
        chk8("rst_readdata", avs.readdata, 8'h80);
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        #1;
        chk1("rst_wait_cs_wr", avs.waitrequest, 1'b1);
        bus_idle();
        #1;
        chk1("rst_wait_idle", avs.waitrequest, 1'b0);
        reset_n = 1'b1;
        init_seq();

        write_check(1'b1, 8'h48, 20);
        write_check(1'b0, 8'h01, 50);
        write_check(1'b0, 8'h0C, 20);

        // Held write: 0x42 accepted, then 0x41 stays asserted through busy.
        npulse_all = 0;
        npulse_41  = 0;
        en_prev    = lcd_en;
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = 1'b1;
        avs.writedata  = 8'h42;
        #1;
        chk1("held_first_accept", avs.waitrequest, 1'b0);
        tick_mon();
        avs.writedata = 8'h41;
        waits = 0;
        for (int c = 1; c <= 100; c++) begin
            tick_mon();
            if (!avs.waitrequest) break;
            waits++;
        end
        chk8("held_stall_cycles", waits[7:0], 8'd19);
        tick_mon();
        bus_idle();
        for (int c = 0; c < 60; c++) tick_mon();
        chk8("held_41_pulses", npulse_41[7:0], 8'd1);
        chk8("held_all_pulses", npulse_all[7:0], 8'd2);
        chk8("held_final_data", lcd_data, 8'h41);
        chk8("held_idle", avs.readdata, 8'h00);

        // Poll reads while busy, then a chipselect=0 read in IDLE.
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = 1'b1;
        avs.writedata  = 8'h55;
        #1;
        tick();
        avs.write = 1'b0;
        avs.read  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk1("poll_wait", avs.waitrequest, 1'b0);
            chk8("poll_busy", avs.readdata, 8'h80);
        end
        repeat (20) tick();
        chk8("poll_idle", avs.readdata, 8'h00);
        avs.chipselect = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk1("nocs_en", lcd_en, 1'b0);
        end
        chk8("nocs_data", lcd_data, 8'h55);
        chk8("nocs_idle", avs.readdata, 8'h00);
        bus_idle();

        // Read and write together: write proceeds, readdata stays valid.
        avs.chipselect = 1'b1;
        avs.read       = 1'b1;
        avs.write      = 1'b1;
        avs.address    = 1'b1;
        avs.writedata  = 8'h5A;
        #1;
        chk1("rw_wait", avs.waitrequest, 1'b0);
        chk8("rw_rd_idle", avs.readdata, 8'h00);
        tick();
        bus_idle();
        chk8("rw_rd_busy", avs.readdata, 8'h80);
        tick();
        chk8("rw_data", lcd_data, 8'h5A);
        chk1("rw_rs", lcd_rs, 1'b1);
        repeat (25) tick();
        chk8("rw_idle", avs.readdata, 8'h00);

        // Reset asserted during EN_HIGH, then the whole init repeats.
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = 1'b1;
        avs.writedata  = 8'h33;
        #1;
        tick();
        bus_idle();
        repeat (4) tick();
        chk1("mid_en_high", lcd_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_en", lcd_en, 1'b0);
        chk8("mid_rst_busy", avs.readdata, 8'h80);
        chk8("mid_rst_data", lcd_data, 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        init_seq();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/lcd_avalon_responder.md
# lcd_avalon_responder

Avalon-MM responder that drives a character LCD with an HD44780-compatible controller over its 8-bit parallel bus. It accepts command and data writes from an Avalon-MM initiator, such as the text-sequencing master, and turns each write into a timed RS/DATA/EN bus cycle followed by an execution wait. After reset it runs the controller power-up initialisation on its own. A status register reports busy so the initiator can poll instead of stalling.

## Interface
Parameters (all in clk cycles; defaults assume 50 MHz):
- SETUP_CYC, 4, RS/DATA setup time before EN rises
- EN_CYC, 25, EN high width
- HOLD_CYC, 4, RS/DATA hold time after EN falls
- WAIT_CYC, 2000, execution wait for ordinary commands and data (40 µs)
- CLEAR_CYC, 82000, execution wait for clear/home (1.64 ms)
- PWRUP_CYC, 750000, power-up delay before initialisation (15 ms)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  1  0 = command register (RS=0), 1 = data register (RS=1)
- chipselect  in  1  qualifies read and write
- read  in  1  status read
- write  in  1  register write
- writedata  in  8  command or character code
- readdata  out  8  status: bit7 = busy, bits6:0 = 0
- waitrequest  out  1  stalls a write while the engine is busy
- LCD_DATA  inout  8  LCD data bus, always driven by this block
- LCD_EN, LCD_RS, LCD_RW  out  1 each  LCD strobes; LCD_RW is tied 0
- LCD_ON, LCD_BLON  out  1 each  power and backlight, constant 1

## Operation
- States: PWR_WAIT, INIT_NEXT, IDLE, SETUP, EN_HIGH, HOLD, EXEC_WAIT. busy is 1 in every state except IDLE.
- Reset entry: go to PWR_WAIT and count PWRUP_CYC cycles, then go to INIT_NEXT.
- INIT_NEXT: issue the next entry of the init ROM with RS=0. The ROM holds 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each entry runs a full bus cycle. After the sixth entry finishes, go to IDLE.
- IDLE: when chipselect & write, latch RS=address and DATA=writedata, then go to SETUP.
- Bus cycle:
  - SETUP holds for SETUP_CYC cycles.
  - EN_HIGH holds for EN_CYC cycles with LCD_EN=1.
  - HOLD holds for HOLD_CYC cycles.
  - EXEC_WAIT holds for CLEAR_CYC cycles if RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise for WAIT_CYC cycles.
  - Next state is INIT_NEXT if initialisation is still running, else IDLE.
- waitrequest = chipselect & write & busy. Reads never stall.
- readdata = {busy, 7'b0}, combinational. A read is valid in any state.
- A write accepted in IDLE completes on the Avalon side in the acceptance cycle (waitrequest=0). Completion on the LCD side is signalled only by busy.
- Writes presented during PWR_WAIT or initialisation are stalled, not dropped.
- read and write asserted together: the write is processed and readdata stays valid. Both are ignored when chipselect=0.
- One shared down-counter serves every timed state; it must be 20 bits wide to cover PWRUP_CYC.

## Timing
- Reset values:
  - LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
  - LCD_ON=1, LCD_BLON=1.
  - busy=1, so readdata=0x80 and waitrequest follows chipselect & write.
- Asserting reset_n mid-cycle drops LCD_EN immediately (asynchronously) and restarts from PWR_WAIT.
- Acceptance edge = cycle 0.
  - LCD_RS and LCD_DATA update at cycle 1.
  - LCD_EN is high from cycle 1+SETUP_CYC through SETUP_CYC+EN_CYC.
  - LCD_RS and LCD_DATA hold their values until the next accepted write.
  - busy falls at cycle 1+SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- Back-to-back writes: a write already held when busy falls is accepted in the first IDLE cycle.
- All LCD outputs are registered. No glitches on LCD_EN.

## Structure
- Package lcd_pkg holds:
  - state enum
  - init ROM array and length (6)
  - command constants CLEAR=0x01, HOME=0x02, FUNC_8BIT_2LINE=0x38, DISP_ON=0x0C, ENTRY_INC=0x06
- Sub-module lcd_bus_cycle handles one timed transfer:
  - inputs: start, rs, data, long_wait
  - outputs: LCD pins, done
  - it owns SETUP/EN_HIGH/HOLD/EXEC_WAIT and the counter
- The top sequences PWR_WAIT, INIT_NEXT and IDLE, and runs the Avalon decode.

## Test plan
Parameters for all scenarios: SETUP=2, EN=5, HOLD=2, WAIT=10, CLEAR=40, PWRUP=20.
- Release reset -> readdata=0x80 for 20 cycles. Then six EN pulses of 5 cycles with RS=0 and DATA 38, 38, 38, 0C, 01, 06. readdata becomes 0x00 only after the 06 wait.
- IDLE, write addr=1 data=0x48 -> waitrequest=0 at acceptance, RS=1 and DATA=0x48 at cycle 1, EN high at cycles 3–7, busy falls at cycle 20.
- Write addr=0 data=0x01 -> EXEC_WAIT lasts 40 cycles and busy falls at cycle 50. Repeat with data=0x0C -> busy falls at cycle 20.
- Hold a write of 0x41 asserted during busy -> waitrequest=1 until IDLE. Accepted exactly once; exactly one EN pulse carries 0x41.
- Assert reset_n=0 during EN_HIGH -> LCD_EN=0 in the same cycle. On release, the power-up and init sequence repeats in full.
- Poll reads during a busy write -> waitrequest=0 and readdata=0x80; in IDLE readdata=0x00. A read with chipselect=0 has no side effects.
